// File: rtl/dm_pkg.sv
// Shared debug-module types: DTM op codes, DMI error codes, DTMCS register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm;

    localparam logic [3:0] DtmVersion = 4'd1;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DMINoError       = 2'd0,
        DMIReservedError = 2'd1,
        DMIOPFailed      = 2'd2,
        DMIBusy          = 2'd3
    } dmi_error_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

endpackage

// File: rtl/dmi_jtag_dtm_core.sv
// TCK-domain DTM core: DMI/DTMCS shift registers plus the request/response FSM toward the DMI CDC.
// Latency: request valid the cycle after Update-DR; response consumed the cycle it arrives.
// Backpressure: request held until req_ready_i; responses always accepted; overlapping DMI access flags busy.
// Ports: TAP control strobes and tdi in, per-register tdo out; req_*/resp_* toward the CDC; dmi_clear_o flushes it.
module dmi_jtag_dtm_core
    import dm::*;
#(
    parameter int unsigned AddrWidth     = 7,
    parameter logic [2:0]  IdleHint      = 3'd1,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 test_logic_reset_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 dmi_select_i,
    input  logic                 dtmcs_select_i,
    input  logic                 tdi_i,
    output logic                 dmi_tdo_o,
    output logic                 dtmcs_tdo_o,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [31:0]          req_data_o,
    output logic [1:0]           req_op_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic [31:0]          resp_data_i,
    input  logic [1:0]           resp_resp_i,
    input  logic                 resp_valid_i,
    output logic                 resp_ready_o,
    output logic                 dmi_clear_o
);

    localparam int unsigned W = AddrWidth + 34;
    localparam logic [5:0] Abits = 6'(AddrWidth);
    localparam logic [CntWidth-1:0] TimeoutLast =
        (TimeoutCycles > 0) ? CntWidth'(TimeoutCycles - 1) : '0;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [31:0]          data;
        logic [1:0]           op;
    } dmi_dr_t;

    typedef enum logic [2:0] {
        Idle,
        Read,
        WaitRead,
        Write,
        WaitWrite
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    dmi_error_e           error_q, error_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    dmi_dr_t              dmi_dr_q;
    dtmcs_t               dtmcs_q;
    dtmcs_t               dtmcs_cap;
    logic                 clear_q;

    logic       busy;
    logic       dmireset;
    logic       hardreset;
    logic [1:0] capture_status;

    // A new DMI access while one is outstanding, or reading status before a
    // read has returned, is reported as busy in the same cycle.
    assign busy = dmi_select_i &
                  ((update_dr_i & (state_q != Idle)) |
                   (capture_dr_i & ((state_q == Read) | (state_q == WaitRead))));

    assign hardreset = update_dr_i & dtmcs_select_i & dtmcs_q.dmihardreset;
    assign dmireset  = update_dr_i & dtmcs_select_i & dtmcs_q.dmireset;

    assign capture_status = busy ? 2'd3 : error_q;

    always_comb begin
        dtmcs_cap         = '0;
        dtmcs_cap.version = DtmVersion;
        dtmcs_cap.abits   = Abits;
        dtmcs_cap.dmistat = error_q;
        dtmcs_cap.idle    = IdleHint;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        error_d = error_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            Idle: begin
                if (update_dr_i && dmi_select_i && error_q == DMINoError) begin
                    addr_d = dmi_dr_q.addr;
                    data_d = dmi_dr_q.data;
                    if (dmi_dr_q.op == DTM_READ) begin
                        state_d = Read;
                    end else if (dmi_dr_q.op == DTM_WRITE) begin
                        state_d = Write;
                    end
                end
            end
            Read: begin
                if (req_ready_i) begin
                    state_d = WaitRead;
                    cnt_d   = '0;
                end
            end
            Write: begin
                if (req_ready_i) begin
                    state_d = WaitWrite;
                    cnt_d   = '0;
                end
            end
            WaitRead, WaitWrite: begin
                if (resp_valid_i) begin
                    if (state_q == WaitRead) begin
                        data_d = resp_data_i;
                    end
                    if (resp_resp_i != 2'd0 && error_q == DMINoError) begin
                        error_d = DMIOPFailed;
                    end
                    state_d = Idle;
                end else if (TimeoutCycles > 0) begin
                    // Giving up returns to Idle, so a response that shows up
                    // later is simply ignored there.
                    if (cnt_q == TimeoutLast) begin
                        if (error_q == DMINoError) begin
                            error_d = DMIOPFailed;
                        end
                        state_d = Idle;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
            end
            default: state_d = Idle;
        endcase

        // Later assignments win: hardreset > dmireset > busy > op errors.
        if (busy) begin
            error_d = DMIBusy;
        end
        if (dmireset) begin
            error_d = DMINoError;
        end
        if (hardreset) begin
            error_d = DMINoError;
            state_d = Idle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= Idle;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= DMINoError;
            cnt_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
            clear_q <= hardreset;
        end
    end

    // Test-Logic-Reset only clears the data registers; transaction state and
    // the sticky error survive it.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dmi_dr_q <= '0;
            dtmcs_q  <= '0;
        end else if (test_logic_reset_i) begin
            dmi_dr_q <= '0;
            dtmcs_q  <= '0;
        end else begin
            if (dmi_select_i) begin
                if (capture_dr_i) begin
                    dmi_dr_q <= {addr_q, data_q, capture_status};
                end else if (shift_dr_i) begin
                    dmi_dr_q <= {tdi_i, dmi_dr_q[W-1:1]};
                end
            end
            if (dtmcs_select_i) begin
                if (capture_dr_i) begin
                    dtmcs_q <= dtmcs_cap;
                end else if (shift_dr_i) begin
                    dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
                end
            end
        end
    end

    assign dmi_tdo_o    = dmi_dr_q[0];
    assign dtmcs_tdo_o  = dtmcs_q[0];
    assign req_valid_o  = (state_q == Read) | (state_q == Write);
    assign req_op_o     = (state_q == Read)  ? DTM_READ  :
                          (state_q == Write) ? DTM_WRITE : DTM_NOP;
    assign req_addr_o   = addr_q;
    assign req_data_o   = data_q;
    assign resp_ready_o = 1'b1;
    assign dmi_clear_o  = clear_q;

endmodule

// File: tb/tb_dmi_jtag_dtm_core.sv
module tb_dmi_jtag_dtm_core;
    import dm::*;

    localparam int AW = 10;
    localparam int W  = AW + 34;
    localparam int TO = 8;
    localparam logic [2:0] IH = 3'd5;

    logic          tck_i = 1'b0;
    logic          trst_ni;
    logic          test_logic_reset_i = 1'b0;
    logic          capture_dr_i = 1'b0;
    logic          shift_dr_i = 1'b0;
    logic          update_dr_i = 1'b0;
    logic          dmi_select_i = 1'b0;
    logic          dtmcs_select_i = 1'b0;
    logic          tdi_i = 1'b0;
    logic          dmi_tdo_o;
    logic          dtmcs_tdo_o;
    logic [AW-1:0] req_addr_o;
    logic [31:0]   req_data_o;
    logic [1:0]    req_op_o;
    logic          req_valid_o;
    logic          req_ready_i = 1'b0;
    logic [31:0]   resp_data_i = '0;
    logic [1:0]    resp_resp_i = '0;
    logic          resp_valid_i = 1'b0;
    logic          resp_ready_o;
    logic          dmi_clear_o;

    dmi_jtag_dtm_core #(
        .AddrWidth    (AW),
        .IdleHint     (IH),
        .TimeoutCycles(TO),
        .CntWidth     (16)
    ) dut (
        .tck_i             (tck_i),
        .trst_ni           (trst_ni),
        .test_logic_reset_i(test_logic_reset_i),
        .capture_dr_i      (capture_dr_i),
        .shift_dr_i        (shift_dr_i),
        .update_dr_i       (update_dr_i),
        .dmi_select_i      (dmi_select_i),
        .dtmcs_select_i    (dtmcs_select_i),
        .tdi_i             (tdi_i),
        .dmi_tdo_o         (dmi_tdo_o),
        .dtmcs_tdo_o       (dtmcs_tdo_o),
        .req_addr_o        (req_addr_o),
        .req_data_o        (req_data_o),
        .req_op_o          (req_op_o),
        .req_valid_o       (req_valid_o),
        .req_ready_i       (req_ready_i),
        .resp_data_i       (resp_data_i),
        .resp_resp_i       (resp_resp_i),
        .resp_valid_i      (resp_valid_i),
        .resp_ready_o      (resp_ready_o),
        .dmi_clear_o       (dmi_clear_o)
    );

    always #5 tck_i = ~tck_i;

    int total = 0;
    int bad   = 0;

    // Reference model: what the debugger should observe.
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;
    logic [1:0]    m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_dmi();
        return 64'({m_addr, m_data, m_err});
    endfunction

    function automatic logic [63:0] exp_dtmcs();
        return 64'(IH) * 64'd4096 + 64'(m_err) * 64'd1024 + 64'(AW) * 64'd16 + 64'd1;
    endfunction

    task automatic tick();
        @(negedge tck_i);
    endtask

    task automatic scan(input bit is_dtmcs, input logic [63:0] din, input bit upd,
                        output logic [63:0] dout);
        int len;
        len  = is_dtmcs ? 32 : W;
        dout = '0;
        dmi_select_i   = !is_dtmcs;
        dtmcs_select_i = is_dtmcs;
        capture_dr_i   = 1'b1;
        tick();
        capture_dr_i = 1'b0;
        shift_dr_i   = 1'b1;
        for (int i = 0; i < len; i++) begin
            dout[i] = is_dtmcs ? dtmcs_tdo_o : dmi_tdo_o;
            tdi_i   = din[i];
            tick();
        end
        shift_dr_i = 1'b0;
        tdi_i      = 1'b0;
        if (upd) begin
            update_dr_i = 1'b1;
            tick();
            update_dr_i = 1'b0;
        end
        dmi_select_i   = 1'b0;
        dtmcs_select_i = 1'b0;
    endtask

    task automatic dtmcs_op(input logic [31:0] din, input bit upd);
        logic [63:0] dout;
        scan(1'b1, 64'(din), upd, dout);
        chk("dtmcs_capture", dout, exp_dtmcs());
        chk("dtmcs_clear_pulse", 64'(dmi_clear_o), 64'(upd && din[17]));
        if (upd && (din[16] || din[17])) m_err = 2'd0;
    endtask

    task automatic dmi_txn(input logic [1:0] op, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [1:0] rresp, input logic [31:0] rdata, input int dly);
        logic [63:0] dout;
        bit exp_req;
        bit seen;
        scan(1'b0, 64'({a, d, op}), 1'b1, dout);
        chk("dmi_capture", dout, exp_dmi());
        exp_req = (m_err == 2'd0) && (op == 2'd1 || op == 2'd2);
        if (m_err == 2'd0) begin
            m_addr = a;
            m_data = d;
        end
        if (exp_req) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (req_valid_o) seen = 1'b1;
                else tick();
            end
            chk("req_valid", 64'(seen), 64'd1);
            if (seen) begin
                chk("req_op", 64'(req_op_o), 64'(op));
                chk("req_addr", 64'(req_addr_o), 64'(a));
                chk("req_data", 64'(req_data_o), 64'(d));
                repeat ($urandom_range(0, 2)) tick();
                req_ready_i = 1'b1;
                tick();
                req_ready_i = 1'b0;
                repeat (dly) tick();
                resp_valid_i = 1'b1;
                resp_data_i  = rdata;
                resp_resp_i  = rresp;
                tick();
                resp_valid_i = 1'b0;
                if (op == 2'd1) m_data = rdata;
                if (rresp != 2'd0 && m_err == 2'd0) m_err = 2'd2;
            end
        end else begin
            repeat (3) begin
                chk("no_req", 64'(req_valid_o), 64'd0);
                tick();
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]   dout;
        logic [AW-1:0] a, a2;
        logic [31:0]   d, d2, rd;

        trst_ni = 1'b1;
        #1 trst_ni = 1'b0;
        repeat (3) tick();
        chk("rst_req_valid", 64'(req_valid_o), 64'd0);
        chk("rst_req_op", 64'(req_op_o), 64'd0);
        chk("rst_req_addr", 64'(req_addr_o), 64'd0);
        chk("rst_req_data", 64'(req_data_o), 64'd0);
        chk("rst_resp_ready", 64'(resp_ready_o), 64'd1);
        chk("rst_dmi_clear", 64'(dmi_clear_o), 64'd0);
        chk("rst_tdo", 64'({dmi_tdo_o, dtmcs_tdo_o}), 64'd0);
        trst_ni = 1'b1;
        tick();
        m_addr = '0; m_data = '0; m_err = 2'd0;

        // DTMCS identification word
        dtmcs_op(32'h0, 1'b0);

        // Read returning data
        dmi_txn(2'd1, 10'h3A5, 32'h0, 2'd0, 32'hDEADBEEF, 2);
        dmi_txn(2'd0, 10'h0, 32'h0, 2'd0, 32'h0, 0);

        // Write with failing response, then sticky error and dmireset
        dmi_txn(2'd2, 10'h010, 32'h1234, 2'd2, 32'h0, 1);
        dmi_txn(2'd0, 10'h0, 32'h0, 2'd0, 32'h0, 0);
        dtmcs_op(32'h0, 1'b0);
        dmi_txn(2'd1, 10'h2AA, 32'h5555, 2'd0, 32'h77, 0);
        dtmcs_op(32'h0001_0000, 1'b1);
        dtmcs_op(32'h0, 1'b0);

        // Busy: second update while the write is still unaccepted
        a = AW'($urandom); d = $urandom; a2 = AW'($urandom); d2 = $urandom;
        scan(1'b0, 64'({a, d, 2'd2}), 1'b1, dout);
        chk("busy_cap0", dout, exp_dmi());
        m_addr = a; m_data = d;
        tick(); tick();
        chk("busy_req_pending", 64'(req_valid_o), 64'd1);
        scan(1'b0, 64'({a2, d2, 2'd1}), 1'b1, dout);
        chk("busy_cap1", dout, exp_dmi());
        m_err = 2'd3;
        chk("busy_addr_held", 64'(req_addr_o), 64'(a));
        chk("busy_data_held", 64'(req_data_o), 64'(d));
        scan(1'b0, 64'h0, 1'b0, dout);
        chk("busy_status", dout, exp_dmi());
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0; tick();
        resp_valid_i = 1'b1; resp_resp_i = 2'd0; resp_data_i = $urandom; tick(); resp_valid_i = 1'b0;
        dtmcs_op(32'h0, 1'b0);
        dtmcs_op(32'h0001_0000, 1'b1);

        // Capture while a read is pending reports busy
        a = AW'($urandom); d = $urandom; rd = $urandom;
        scan(1'b0, 64'({a, d, 2'd1}), 1'b1, dout);
        chk("rdbusy_cap0", dout, exp_dmi());
        m_addr = a; m_data = d;
        scan(1'b0, 64'h0, 1'b0, dout);
        m_err = 2'd3;
        chk("rdbusy_status", dout, exp_dmi());
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        resp_valid_i = 1'b1; resp_resp_i = 2'd0; resp_data_i = rd; tick(); resp_valid_i = 1'b0;
        m_data = rd;
        dtmcs_op(32'h0001_0000, 1'b1);
        dmi_txn(2'd0, 10'h0, 32'h0, 2'd0, 32'h0, 0);

        // Response in the last cycle before timeout is accepted
        dmi_txn(2'd1, AW'($urandom), $urandom, 2'd0, $urandom, TO - 1);
        dmi_txn(2'd0, 10'h0, 32'h0, 2'd0, 32'h0, 0);

        // No response: timeout, late response dropped
        a = AW'($urandom); d = $urandom;
        scan(1'b0, 64'({a, d, 2'd1}), 1'b1, dout);
        chk("to_cap0", dout, exp_dmi());
        m_addr = a; m_data = d;
        chk("to_req", 64'(req_valid_o), 64'd1);
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        repeat (TO) tick();
        resp_valid_i = 1'b1; resp_data_i = ~d; resp_resp_i = 2'd0; tick(); resp_valid_i = 1'b0;
        m_err = 2'd2;
        chk("to_no_req", 64'(req_valid_o), 64'd0);
        scan(1'b0, 64'h0, 1'b0, dout);
        chk("to_capture", dout, exp_dmi());
        dtmcs_op(32'h0001_0000, 1'b1);

        // Hardreset from WaitWrite after a busy hit; DTMCS DR pre-loaded
        scan(1'b1, 64'h0002_0000, 1'b0, dout);
        chk("hr_dtmcs_cap", dout, exp_dtmcs());
        a = AW'($urandom); d = $urandom;
        scan(1'b0, 64'({a, d, 2'd2}), 1'b1, dout);
        chk("hr_cap0", dout, exp_dmi());
        m_addr = a; m_data = d;
        req_ready_i = 1'b1; tick(); req_ready_i = 1'b0;
        dmi_select_i = 1'b1; update_dr_i = 1'b1; tick();
        update_dr_i = 1'b0; dmi_select_i = 1'b0;
        m_err = 2'd3;
        chk("hr_clear_before", 64'(dmi_clear_o), 64'd0);
        dtmcs_select_i = 1'b1; update_dr_i = 1'b1; tick();
        update_dr_i = 1'b0; dtmcs_select_i = 1'b0;
        m_err = 2'd0;
        chk("hr_clear_pulse", 64'(dmi_clear_o), 64'd1);
        resp_valid_i = 1'b1; resp_resp_i = 2'd2; resp_data_i = $urandom; tick(); resp_valid_i = 1'b0;
        chk("hr_clear_one_cycle", 64'(dmi_clear_o), 64'd0);
        dtmcs_op(32'h0, 1'b0);
        dmi_txn(2'd1, AW'($urandom), $urandom, 2'd0, $urandom, 3);
        dmi_txn(2'd0, 10'h0, 32'h0, 2'd0, 32'h0, 0);

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            logic [1:0] op, rr;
            op = 2'($urandom_range(0, 3));
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            dmi_txn(op, AW'($urandom), $urandom, rr, $urandom, int'($urandom_range(0, TO - 1)));
            if (m_err != 2'd0 && $urandom_range(0, 1) == 1)
                dtmcs_op($urandom_range(0, 1) ? 32'h0002_0000 : 32'h0001_0000, 1'b1);
        end
        dmi_txn(2'd0, 10'h0, 32'h0, 2'd0, 32'h0, 0);

        // Test-Logic-Reset clears the shift register
        scan(1'b0, 64'h1, 1'b0, dout);
        test_logic_reset_i = 1'b1; tick(); test_logic_reset_i = 1'b0;
        chk("tlr_tdo", 64'(dmi_tdo_o), 64'd0);

        // trst in the middle of a read
        if (m_err != 2'd0) dtmcs_op(32'h0001_0000, 1'b1);
        scan(1'b0, 64'({AW'($urandom), 32'($urandom), 2'd1}), 1'b1, dout);
        chk("trst_req_before", 64'(req_valid_o), 64'd1);
        trst_ni = 1'b0;
        #1;
        chk("trst_req_valid", 64'(req_valid_o), 64'd0);
        chk("trst_dmi_clear", 64'(dmi_clear_o), 64'd0);
        tick();
        trst_ni = 1'b1;
        tick();
        m_addr = '0; m_data = '0; m_err = 2'd0;
        scan(1'b0, 64'h0, 1'b0, dout);
        chk("trst_capture", dout, exp_dmi());
        dtmcs_op(32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
